// File: rtl/pwm_reg_pkg.sv
// pwm_reg_pkg: shared constants for the PWM register bank / update scheduler.
//   - register address map (duty low, duty high, ctrl, command)
//   - command and ctrl bit positions
//   - scheduler FSM state enum
package pwm_reg_pkg;

  localparam int ADDR_DUTY_LO = 0;
  localparam int ADDR_DUTY_HI = 1;
  localparam int ADDR_CTRL    = 2;
  localparam int ADDR_CMD     = 3;

  localparam int CMD_COMMIT_BIT = 0;
  localparam int CMD_ABORT_BIT  = 1;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_INV_BIT = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

endpackage

// File: rtl/pwm_reg_wdog.sv
// pwm_reg_wdog: link watchdog counter.
//   Reloads to RELOAD whenever load_i is high, otherwise counts down and
//   saturates at zero. expire_o pulses for one cycle on the first cycle the
//   count sits at zero.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load_i      reload strobe (host activity)
//   expire_o    one-cycle expiry pulse
module pwm_reg_wdog #(
  parameter int          W      = 24,
  parameter logic [W-1:0] RELOAD = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic expire_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         zero_q, zero_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    zero_d = (cnt_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= RELOAD;
      zero_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
    end
  end

  // zero_q lags the count by one cycle, so this is high only on the first
  // cycle of a zero count.
  assign expire_o = (cnt_q == '0) && !zero_q;

endmodule

// File: rtl/pwm_reg_sched.sv
// pwm_reg_sched: register bank and update scheduler feeding the PWM core.
//   Host byte writes land in a shadow bank. A COMMIT arms the scheduler; the
//   shadow is copied into the active configuration on the next period_end,
//   so the core only ever sees a complete duty word. ABORT disarms.
//   Optional link watchdog (macro PWMREG_WDOG_EN) forces pwm_en low and sets
//   a sticky wdog_trip flag when the host stops writing.
//
// Handshake: regDataValid is a single-cycle strobe with no back-pressure;
// regAddr/regData are sampled only in a cycle where regDataValid is high.
// period_end is a one-cycle pulse sampled every cycle.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   regAddr/regData/regDataValid  register write interface
//   period_end      last count of a PWM period
//   duty/pwm_en/pwm_inv  active configuration (registered)
//   update_pending  commit armed, waiting for period_end
//   update_done     one-cycle pulse when a commit was applied
//   wdog_trip       sticky watchdog flag (0 without PWMREG_WDOG_EN)
//   dbg_state       scheduler FSM state
module pwm_reg_sched
  import pwm_reg_pkg::*;
#(
  parameter int          REGBITS     = 2,
  parameter int          DUTYBITS    = 16,
  parameter logic [15:0] DUTY_MAX    = 16'hFFFF,
  parameter logic [23:0] WDOG_CYCLES = 24'd12_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REGBITS-1:0]  regAddr,
  input  logic [7:0]          regData,
  input  logic                regDataValid,
  input  logic                period_end,
  output logic [DUTYBITS-1:0] duty,
  output logic                pwm_en,
  output logic                pwm_inv,
  output logic                update_pending,
  output logic                update_done,
  output logic                wdog_trip,
  output state_e              dbg_state
);

  localparam logic [DUTYBITS-1:0] DUTY_CLAMP = DUTY_MAX[DUTYBITS-1:0];

  // Write decode
  logic wr_lo, wr_hi, wr_ctrl, wr_cmd;
  logic cmd_commit, cmd_abort;

  assign wr_lo   = regDataValid && (regAddr == REGBITS'(ADDR_DUTY_LO));
  assign wr_hi   = regDataValid && (regAddr == REGBITS'(ADDR_DUTY_HI));
  assign wr_ctrl = regDataValid && (regAddr == REGBITS'(ADDR_CTRL));
  assign wr_cmd  = regDataValid && (regAddr == REGBITS'(ADDR_CMD));

  // ABORT takes precedence when both command bits are set.
  assign cmd_abort  = wr_cmd && regData[CMD_ABORT_BIT];
  assign cmd_commit = wr_cmd && regData[CMD_COMMIT_BIT] && !regData[CMD_ABORT_BIT];

  // Shadow bank
  logic [7:0]          sh_lo_q, sh_lo_d;
  logic [DUTYBITS-9:0] sh_hi_q, sh_hi_d;
  logic                sh_en_q, sh_en_d;
  logic                sh_inv_q, sh_inv_d;

  always_comb begin
    sh_lo_d  = sh_lo_q;
    sh_hi_d  = sh_hi_q;
    sh_en_d  = sh_en_q;
    sh_inv_d = sh_inv_q;
    if (wr_lo)   sh_lo_d = regData;
    if (wr_hi)   sh_hi_d = regData[DUTYBITS-9:0];
    if (wr_ctrl) begin
      sh_en_d  = regData[CTRL_EN_BIT];
      sh_inv_d = regData[CTRL_INV_BIT];
    end
  end

  // Scheduler FSM
  state_e state_q, state_d;
  logic   apply;

  always_comb begin
    state_d = state_q;
    apply   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // period_end here is ignored even if COMMIT arrives with it.
        if (cmd_commit) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (cmd_abort) begin
          state_d = ST_IDLE;
        end else if (period_end) begin
          apply   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Active configuration. The copy reads the registered shadow, so a byte
  // written in the apply cycle waits for the next commit.
  logic [DUTYBITS-1:0] duty_cand, duty_clamped;
  logic [DUTYBITS-1:0] duty_q, duty_d;
  logic                en_q, en_d;
  logic                inv_q, inv_d;
  logic                done_q, done_d;
  logic                trip_q, trip_d;
  logic                wdog_expire;

  assign duty_cand    = {sh_hi_q, sh_lo_q};
  assign duty_clamped = (duty_cand > DUTY_CLAMP) ? DUTY_CLAMP : duty_cand;

`ifdef PWMREG_WDOG_EN
  pwm_reg_wdog #(
    .W      (24),
    .RELOAD (WDOG_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (regDataValid),
    .expire_o (wdog_expire)
  );
`else
  assign wdog_expire = 1'b0;
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
`endif

  always_comb begin
    duty_d = duty_q;
    en_d   = en_q;
    inv_d  = inv_q;
    done_d = apply;
    trip_d = trip_q;
    if (apply) begin
      duty_d = duty_clamped;
      en_d   = sh_en_q;
      inv_d  = sh_inv_q;
      trip_d = 1'b0;
    end
    // Expiry overrides a coincident apply: the link is considered dead.
    if (wdog_expire) begin
      en_d   = 1'b0;
      trip_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sh_lo_q  <= '0;
      sh_hi_q  <= '0;
      sh_en_q  <= 1'b0;
      sh_inv_q <= 1'b0;
      duty_q   <= '0;
      en_q     <= 1'b0;
      inv_q    <= 1'b0;
      done_q   <= 1'b0;
      trip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_lo_q  <= sh_lo_d;
      sh_hi_q  <= sh_hi_d;
      sh_en_q  <= sh_en_d;
      sh_inv_q <= sh_inv_d;
      duty_q   <= duty_d;
      en_q     <= en_d;
      inv_q    <= inv_d;
      done_q   <= done_d;
      trip_q   <= trip_d;
    end
  end

  assign duty           = duty_q;
  assign pwm_en         = en_q;
  assign pwm_inv        = inv_q;
  assign update_pending = (state_q == ST_ARMED);
  assign update_done    = done_q;
  assign wdog_trip      = trip_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_pwm_reg_sched.sv
// tb_pwm_reg_sched: self-checking bench for pwm_reg_sched.
// Two instances share stimulus: dut (DUTY_MAX default) and dut_c
// (DUTY_MAX = 0x0800). A bench-side model of shadow/FSM predicts each
// apply and pushes the expected active config onto exp_q; the entry is
// popped and compared in the cycle update_done is due.
module tb_pwm_reg_sched;
  import pwm_reg_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  regAddr;
  logic [7:0]  regData;
  logic        regDataValid;
  logic        period_end;

  logic [15:0] duty, duty_c;
  logic        pwm_en, pwm_en_c, pwm_inv, pwm_inv_c;
  logic        pend, pend_c, done, done_c, trip, trip_c;
  state_e      dbg_state, dbg_state_c;

  int n_tests = 0;
  int n_fail  = 0;

  // {duty, duty_clamped, en, inv}
  logic [33:0] exp_q[$];

  // Bench model
  logic [7:0] m_lo, m_hi;
  logic       m_en, m_inv, m_armed;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pwm_reg_sched #(
    .REGBITS(2), .DUTYBITS(16), .DUTY_MAX(16'hFFFF), .WDOG_CYCLES(24'd100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .regAddr(regAddr), .regData(regData),
    .regDataValid(regDataValid), .period_end(period_end),
    .duty(duty), .pwm_en(pwm_en), .pwm_inv(pwm_inv),
    .update_pending(pend), .update_done(done), .wdog_trip(trip),
    .dbg_state(dbg_state)
  );

  pwm_reg_sched #(
    .REGBITS(2), .DUTYBITS(16), .DUTY_MAX(16'h0800), .WDOG_CYCLES(24'd100)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .regAddr(regAddr), .regData(regData),
    .regDataValid(regDataValid), .period_end(period_end),
    .duty(duty_c), .pwm_en(pwm_en_c), .pwm_inv(pwm_inv_c),
    .update_pending(pend_c), .update_done(done_c), .wdog_trip(trip_c),
    .dbg_state(dbg_state_c)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] clamp(input logic [15:0] d);
    return (d > 16'h0800) ? 16'h0800 : d;
  endfunction

  task automatic model_reset();
    m_lo = 8'h00; m_hi = 8'h00; m_en = 1'b0; m_inv = 1'b0; m_armed = 1'b0;
    exp_q.delete();
  endtask

  // One clock of stimulus with model update and per-cycle checks.
  task automatic cyc(input bit v, input logic [1:0] a, input logic [7:0] d, input bit pe);
    bit apply;
    logic [33:0] e;
    @(negedge clk);
    regDataValid = v; regAddr = a; regData = d; period_end = pe;
    apply = m_armed && pe && !(v && a == 2'd3 && d[1]);
    if (apply) exp_q.push_back({m_hi, m_lo, clamp({m_hi, m_lo}), m_en, m_inv});
    if (apply) m_armed = 1'b0;
    if (v) begin
      case (a)
        2'd0: m_lo = d;
        2'd1: m_hi = d;
        2'd2: begin m_en = d[0]; m_inv = d[1]; end
        default: begin
          if (d[1]) m_armed = 1'b0;
          else if (d[0] && !apply) m_armed = 1'b1;
        end
      endcase
    end
    @(posedge clk);
    #1;
    regDataValid = 1'b0; regAddr = 2'd0; regData = 8'h00; period_end = 1'b0;
    check("pending", {31'd0, pend}, {31'd0, m_armed});
    check("pending_c", {31'd0, pend_c}, {31'd0, m_armed});
    check("state", 32'(dbg_state), m_armed ? 32'(ST_ARMED) : 32'(ST_IDLE));
    check("done", {31'd0, done}, {31'd0, apply});
    check("done_c", {31'd0, done_c}, {31'd0, apply});
    if (apply) begin
      if (exp_q.size() == 0) begin
        check("exp_q_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("duty", {16'd0, duty}, {16'd0, e[33:18]});
        check("duty_clamped", {16'd0, duty_c}, {16'd0, e[17:2]});
        check("en", {31'd0, pwm_en}, {31'd0, e[1]});
        check("inv", {31'd0, pwm_inv}, {31'd0, e[0]});
      end
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cyc(1'b1, a, d, 1'b0);
  endtask

  task automatic pe();
    cyc(1'b0, 2'd0, 8'h00, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 8'h00, 1'b0);
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] d, input logic [15:0] dc,
                               input logic en, input logic inv);
    check({tag, "_duty"}, {16'd0, duty}, {16'd0, d});
    check({tag, "_duty_c"}, {16'd0, duty_c}, {16'd0, dc});
    check({tag, "_en"}, {31'd0, pwm_en}, {31'd0, en});
    check({tag, "_inv"}, {31'd0, pwm_inv}, {31'd0, inv});
  endtask

  initial begin
    rst_n = 1'b0; regAddr = 2'd0; regData = 8'h00; regDataValid = 1'b0; period_end = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("reset_pending", {31'd0, pend}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_trip", {31'd0, trip}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Shadow writes without commit never reach the active config.
    wr(2'd0, 8'hAA); wr(2'd1, 8'h55); wr(2'd2, 8'h03);
    pe(); idle(2); pe(); idle(2); pe();
    check_outputs("nocommit", 16'h0000, 16'h0000, 1'b0, 1'b0);

    // Basic commit and apply.
    wr(2'd0, 8'h34); wr(2'd1, 8'h12); wr(2'd2, 8'h01); wr(2'd3, 8'h01);
    idle(2);
    pe();
    check_outputs("basic", 16'h1234, 16'h0800, 1'b1, 1'b0);
    idle(1);
    check("basic_done_once", {31'd0, done}, 32'd0);

    // Arm then ABORT (both bits set) -> nothing applied.
    wr(2'd0, 8'h78); wr(2'd2, 8'h02); wr(2'd3, 8'h01);
    wr(2'd3, 8'h03);
    pe();
    check_outputs("abort", 16'h1234, 16'h0800, 1'b1, 1'b0);

    // ABORT coincident with period_end while armed.
    wr(2'd3, 8'h01);
    cyc(1'b1, 2'd3, 8'h02, 1'b1);
    check_outputs("abort_pe", 16'h1234, 16'h0800, 1'b1, 1'b0);

    // COMMIT with period_end while idle arms only; shadow write coincident
    // with the apply uses the old low byte.
    wr(2'd0, 8'h56); wr(2'd1, 8'h07); wr(2'd2, 8'h01);
    cyc(1'b1, 2'd3, 8'h01, 1'b1);
    check_outputs("commit_pe", 16'h1234, 16'h0800, 1'b1, 1'b0);
    idle(1);
    cyc(1'b1, 2'd0, 8'h99, 1'b1);
    check_outputs("coinc_wr", 16'h0756, 16'h0756, 1'b1, 1'b0);
    wr(2'd3, 8'h01); pe();
    check_outputs("new_lo", 16'h0799, 16'h0799, 1'b1, 1'b0);

    // Clamp boundary: exactly DUTY_MAX, and DUTY_MAX+1.
    wr(2'd0, 8'h00); wr(2'd1, 8'h08); wr(2'd3, 8'h01); pe();
    check_outputs("clamp_eq", 16'h0800, 16'h0800, 1'b1, 1'b0);
    wr(2'd0, 8'h01); wr(2'd3, 8'h01); pe();
    check_outputs("clamp_gt", 16'h0801, 16'h0800, 1'b1, 1'b0);

    // Randomised traffic, dense enough that a watchdog never expires.
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
          ($urandom_range(0, 3) == 0));
    end
    // Guarantee at least one more apply from a known shadow.
    wr(2'd0, 8'hCD); wr(2'd1, 8'hAB); wr(2'd2, 8'h03); wr(2'd3, 8'h01); pe();
    check_outputs("post_rand", 16'hABCD, 16'h0800, 1'b1, 1'b1);

    // Reset while armed discards the commit.
    wr(2'd2, 8'h00); wr(2'd3, 8'h01);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs("mid_reset", 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("mid_reset_pending", {31'd0, pend}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    pe(); pe();
    check_outputs("after_reset", 16'h0000, 16'h0000, 1'b0, 1'b0);

`ifdef PWMREG_WDOG_EN
    // Watchdog: silence for >100 cycles trips it; a later apply restores.
    wr(2'd0, 8'h22); wr(2'd1, 8'h01); wr(2'd2, 8'h01); wr(2'd3, 8'h01); pe();
    check_outputs("wd_pre", 16'h0122, 16'h0122, 1'b1, 1'b0);
    idle(40);
    check("wd_early_trip", {31'd0, trip}, 32'd0);
    check("wd_early_en", {31'd0, pwm_en}, 32'd1);
    idle(70);
    check("wd_trip", {31'd0, trip}, 32'd1);
    check("wd_en_forced", {31'd0, pwm_en}, 32'd0);
    wr(2'd3, 8'h01);
    m_en = 1'b1;
    pe();
    check("wd_trip_clear", {31'd0, trip}, 32'd0);
    check("wd_en_restore", {31'd0, pwm_en}, 32'd1);
`else
    idle(120);
    check("no_wdog_trip", {31'd0, trip}, 32'd0);
`endif

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net: the bench must terminate even if a task stalls.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
